mem_stage_access: RTL

//   MEM-stage data-bus master. Consumes the EXE/MEM pipeline register's memory fields: address, store data, ctrl and op.

---
 rtl/mem_stage_access_if.sv | 23 ++
 rtl/mem_stage_access.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_if.sv
// Data-bus bundle between the MEM-stage access master and memory.
// The master drives req/we/addr/be/wdata; the slave returns ack/rdata.
interface mem_stage_access_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage_access.sv
// MEM-stage data-bus master: one load/store per instruction, stalls the pipe until done.
// Optional bus timeout (exception code 7) enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_stage_access #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [31:0]         mem_data,
  input  logic [1:0]          mem_ctrl,
  input  logic [1:0]          mem_op,
  input  logic                mem_sext,
  input  logic                flush,
  mem_stage_access_if.master  bus,
  output logic                stall,
  output logic [31:0]         load_data,
  output logic                load_valid,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic [ADDR_W-1:0]   exc_badvaddr
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  function automatic logic [3:0] gen_be(input logic [1:0] op, input logic [1:0] n);
    case (op)
      2'b00:   gen_be = 4'b0001 << n;
      2'b01:   gen_be = n[1] ? 4'b1100 : 4'b0011;
      default: gen_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] gen_wdata(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'b00:   gen_wdata = {4{d[7:0]}};
      2'b01:   gen_wdata = {2{d[15:0]}};
      default: gen_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] ext_load(input logic [1:0] op, input logic [1:0] n,
                                           input logic sext, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    b = d[{n, 3'b000} +: 8];
    h = n[1] ? d[31:16] : d[15:0];
    case (op)
      2'b00: begin
        s = b;
        ext_load = sext ? s : {24'h0, b};
      end
      2'b01: begin
        s = h;
        ext_load = sext ? s : {16'h0, h};
      end
      default: ext_load = d;
    endcase
  endfunction

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_is_load;
  logic [1:0]        r_op;
  logic [1:0]        r_lane;
  logic              r_sext;
  logic              r_kill;
  logic [31:0]       r_load_data;

  logic w_acc, w_aligned, w_start, w_misal, w_tmo, w_tmo_done;

  assign w_acc     = (mem_ctrl == 2'b01) || (mem_ctrl == 2'b10);
  assign w_aligned = (mem_op == 2'b00) ||
                     ((mem_op == 2'b01) && !mem_addr[0]) ||
                     (mem_op[1] && (mem_addr[1:0] == 2'b00));
  assign w_start   = (r_state == S_IDLE) && w_acc && w_aligned && !flush;
  assign w_misal   = (r_state == S_IDLE) && w_acc && !w_aligned && !flush;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_tmo;
  logic [ADDR_W-1:0] r_vaddr;

  // Ack in the same cycle as the last wait cycle takes priority over timeout.
  assign w_tmo      = (r_state == S_BUSY) && !bus.bus_ack && (r_cnt == CNT_LAST);
  assign w_tmo_done = r_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
      r_vaddr <= '0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
      r_vaddr <= mem_addr;
    end else if (r_state == S_BUSY && !bus.bus_ack) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_tmo) r_tmo <= 1'b1;
    end
  end
`else
  assign w_tmo      = 1'b0;
  assign w_tmo_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    bus.bus_req  = 1'b0;
    load_valid   = 1'b0;
    exc_valid    = 1'b0;
    exc_code     = 5'd0;
    exc_badvaddr = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          stall  = 1'b1;
          w_next = S_BUSY;
        end else if (w_misal) begin
          exc_valid    = 1'b1;
          exc_code     = (mem_ctrl == 2'b01) ? 5'd4 : 5'd5;
          exc_badvaddr = mem_addr;
        end
      end
      S_BUSY: begin
        bus.bus_req = 1'b1;
        stall       = 1'b1;
        if (bus.bus_ack || w_tmo) w_next = S_DONE;
      end
      S_DONE: begin
        w_next     = S_IDLE;
        load_valid = r_is_load && !r_kill && !w_tmo_done && !flush;
`ifdef MEM_BUS_TIMEOUT_EN
        if (w_tmo_done && !r_kill) begin
          exc_valid    = 1'b1;
          exc_code     = 5'd7;
          exc_badvaddr = r_vaddr;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bus fields are captured at start and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= 4'h0;
      r_wdata     <= 32'h0;
      r_is_load   <= 1'b0;
      r_op        <= 2'b00;
      r_lane      <= 2'b00;
      r_sext      <= 1'b0;
      r_kill      <= 1'b0;
      r_load_data <= 32'h0;
    end else begin
      if (w_start) begin
        r_addr    <= {mem_addr[ADDR_W-1:2], 2'b00};
        r_we      <= (mem_ctrl == 2'b10);
        r_be      <= gen_be(mem_op, mem_addr[1:0]);
        r_wdata   <= gen_wdata(mem_op, mem_data);
        r_is_load <= (mem_ctrl == 2'b01);
        r_op      <= mem_op;
        r_lane    <= mem_addr[1:0];
        r_sext    <= mem_sext;
        r_kill    <= 1'b0;
      end
      if (r_state == S_BUSY && flush) r_kill <= 1'b1;
      if (r_state == S_BUSY && bus.bus_ack)
        r_load_data <= ext_load(r_op, r_lane, r_sext, bus.bus_rdata);
    end
  end

  assign bus.bus_addr  = r_addr;
  assign bus.bus_we    = r_we;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;
  assign load_data     = r_load_data;

endmodule
